// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - 4-channel PWM controller with period-aligned, slew-limited duty updates
module pwm_ramp_ctrl #(
    parameter int NUM_CH = 4,
    parameter int PERIOD = 100,
    parameter int CW     = 8,
    parameter int STEP   = 1,
    localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic [CW-1:0]     cfg_duty,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick,
    output logic              busy
);

    localparam logic [CW-1:0] LAST   = CW'(PERIOD - 1);
    localparam logic [CW-1:0] PMAX   = CW'(PERIOD);
    localparam logic [CW:0]   STEP_W = (CW + 1)'(STEP);

    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     cur_q [NUM_CH];
    logic [CW-1:0]     cur_d [NUM_CH];
    logic [CW-1:0]     tgt_q [NUM_CH];
    logic [CW-1:0]     tgt_d [NUM_CH];
    logic              pend_q, pend_d;
    logic [CHW-1:0]    pend_ch_q, pend_ch_d;
    logic [CW-1:0]     pend_duty_q, pend_duty_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              tick_q, tick_d;

    logic              bnd;
    logic              xfer;
    logic              apply;
    logic [CW-1:0]     duty_clamped;

    // One slew step toward the target; the extra bit keeps up/down moves from wrapping.
    function automatic logic [CW-1:0] ramp_step(input logic [CW-1:0] cur, input logic [CW-1:0] tgt);
        logic [CW:0] cur_w;
        logic [CW:0] tgt_w;
        logic [CW:0] up_w;
        cur_w = {1'b0, cur};
        tgt_w = {1'b0, tgt};
        up_w  = cur_w + STEP_W;
        if (cur_w < tgt_w) begin
            return (up_w > tgt_w) ? tgt : up_w[CW-1:0];
        end else if (cur_w > tgt_w) begin
            if (cur_w < tgt_w + STEP_W) begin
                return tgt;
            end
            return CW'(cur_w - STEP_W);
        end
        return cur;
    endfunction

    // Period counter and boundary detection; stopped counter parks at zero.
    always_comb begin
        bnd     = enable && (count_q == LAST);
        count_d = (!enable || bnd) ? '0 : count_q + 1'b1;
        tick_d  = bnd;
    end

    // Per-channel duty tracking: slew at boundaries while running, snap to target while stopped.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cur_d[i] = cur_q[i];
            pwm_d[i] = enable && (count_q < cur_q[i]);
            if (!enable) begin
                cur_d[i] = tgt_q[i];
            end else if (bnd) begin
                cur_d[i] = ramp_step(cur_q[i], tgt_q[i]);
            end
        end
    end

    // Single-entry request slot; its contents become a target at the next boundary (or next cycle when stopped).
    always_comb begin
        duty_clamped = (cfg_duty > PMAX) ? PMAX : cfg_duty;
        xfer         = cfg_valid && !pend_q;
        apply        = pend_q && (!enable || bnd);
        tgt_d        = tgt_q;
        pend_d       = pend_q;
        pend_ch_d    = pend_ch_q;
        pend_duty_d  = pend_duty_q;
        if (apply) begin
            tgt_d[pend_ch_q] = pend_duty_q;
            pend_d           = 1'b0;
        end else if (xfer) begin
            pend_d      = 1'b1;
            pend_ch_d   = cfg_ch;
            pend_duty_d = duty_clamped;
        end
    end

    // Busy while a request waits or any channel has not yet reached its target.
    always_comb begin
        busy = pend_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cur_q[i] != tgt_q[i]) begin
                busy = 1'b1;
            end
        end
    end

    assign cfg_ready   = !pend_q;
    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;

    // State registers; reset discards any in-flight request and ramp.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q     <= '0;
            cur_q       <= '{default: '0};
            tgt_q       <= '{default: '0};
            pend_q      <= 1'b0;
            pend_ch_q   <= '0;
            pend_duty_q <= '0;
            pwm_q       <= '0;
            tick_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            cur_q       <= cur_d;
            tgt_q       <= tgt_d;
            pend_q      <= pend_d;
            pend_ch_q   <= pend_ch_d;
            pend_duty_q <= pend_duty_d;
            pwm_q       <= pwm_d;
            tick_q      <= tick_d;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - scoreboard bench for pwm_ramp_ctrl against a behavioural model
module tb_pwm_ramp_ctrl;

    localparam int P    = 100;
    localparam int STEP = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_duty;
    logic [3:0] pwm_out;
    logic       period_tick;
    logic       busy;

    pwm_ramp_ctrl #(.NUM_CH(4), .PERIOD(P), .CW(8), .STEP(STEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_duty   (cfg_duty),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       tick;
        logic [3:0] pwm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state
    int   m_count;
    int   m_cur[4];
    int   m_tgt[4];
    bit   m_pend;
    int   m_pch;
    int   m_pduty;
    exp_t m_out;

    always @(posedge clk) begin
        bit m_bnd, m_xfer, m_apply, m_busy;
        if (!rst_n) begin
            m_count = 0;
            m_pend  = 0;
            m_pch   = 0;
            m_pduty = 0;
            for (int i = 0; i < 4; i++) begin
                m_cur[i] = 0;
                m_tgt[i] = 0;
            end
            m_out.pwm  = '0;
            m_out.tick = 1'b0;
        end else begin
            m_bnd   = enable && (m_count == P - 1);
            m_xfer  = cfg_valid && !m_pend;
            m_apply = m_pend && (!enable || m_bnd);
            for (int i = 0; i < 4; i++) begin
                m_out.pwm[i] = enable && (m_count < m_cur[i]);
            end
            m_out.tick = m_bnd;
            for (int i = 0; i < 4; i++) begin
                if (!enable) begin
                    m_cur[i] = m_tgt[i];
                end else if (m_bnd) begin
                    if (m_cur[i] < m_tgt[i]) begin
                        m_cur[i] = (m_cur[i] + STEP > m_tgt[i]) ? m_tgt[i] : m_cur[i] + STEP;
                    end else if (m_cur[i] > m_tgt[i]) begin
                        m_cur[i] = (m_cur[i] - STEP < m_tgt[i]) ? m_tgt[i] : m_cur[i] - STEP;
                    end
                end
            end
            if (m_apply) begin
                m_tgt[m_pch] = m_pduty;
                m_pend = 0;
            end else if (m_xfer) begin
                m_pend  = 1;
                m_pch   = int'(cfg_ch);
                m_pduty = (int'(cfg_duty) > P) ? P : int'(cfg_duty);
            end
            m_count = !enable ? 0 : (m_bnd ? 0 : m_count + 1);
        end
        m_busy = m_pend;
        for (int i = 0; i < 4; i++) begin
            if (m_cur[i] != m_tgt[i]) m_busy = 1;
        end
        m_out.busy  = m_busy;
        m_out.ready = !m_pend;
        exp_q.push_back(m_out);
    end

    // Monitor: every cycle the DUT presents registered outputs, compare with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({cfg_ready, busy, period_tick, pwm_out} !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got ready=%b busy=%b tick=%b pwm=%b exp ready=%b busy=%b tick=%b pwm=%b",
                         $time, cfg_ready, busy, period_tick, pwm_out, e.ready, e.busy, e.tick, e.pwm);
            end
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, expv, $time);
        end
    endtask

    task automatic send(input int ch, input int duty);
        int n = 0;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_duty  = 8'(duty);
        while (!cfg_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("send_timeout", n, 0);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic count_high(input int ch, output int n);
        n = 0;
        repeat (P) begin
            @(negedge clk);
            n += int'(pwm_out[ch]);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (!period_tick && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("tick_timeout", n, 0);
    endtask

    initial begin
        int hi;
        int gap;
        rst_n     = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_duty  = '0;
        repeat (5) @(negedge clk);
        chk("reset_ready", int'(cfg_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pwm", int'(pwm_out), 0);
        rst_n = 1'b1;

        // Small ramp on ch0
        enable = 1'b1;
        send(0, 3);
        wait_idle(1000);
        count_high(0, hi);
        chk("ch0_high_cycles", hi, 3);

        // Full ramp up and down on ch1
        send(1, 100);
        wait_idle(12000);
        count_high(1, hi);
        chk("ch1_const_high", hi, P);
        send(1, 0);
        wait_idle(12000);
        count_high(1, hi);
        chk("ch1_const_low", hi, 0);

        // Clamp plus a back-to-back second request held off by cfg_ready
        send(2, 200);
        send(2, 50);
        wait_idle(12000);
        count_high(2, hi);
        chk("ch2_after_clamp", hi, 50);

        // Request accepted exactly on the boundary cycle, then tick spacing
        wait_tick();
        repeat (P - 1) @(negedge clk);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd3;
        cfg_duty  = 8'd5;
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_tick();
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!period_tick && gap < 300);
        chk("tick_spacing", gap, P);
        wait_idle(2000);

        // Stop mid-ramp
        send(0, 90);
        repeat (300) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("stop_pwm_low", int'(pwm_out), 0);
        repeat (3) @(negedge clk);
        chk("stop_snapped", int'(busy), 0);
        enable = 1'b1;

        // Randomised requests with occasional stops
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 3) == 0) enable = ~enable;
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 400)) @(negedge clk);
        end
        enable = 1'b1;

        // Reset mid-ramp
        send(3, 80);
        repeat (400) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_ready", int'(cfg_ready), 1);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_pwm", int'(pwm_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
